// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: control word, branch-predictor counter encoding, default history width.
package rv32i_types;

  localparam int GHR_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } bp_ctr_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch;
    logic       jump;
    logic       regwrite;
  } rv32i_control_word;

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the gshare predictor.
interface gshare_predictor_if
  import rv32i_types::*;
#(
  parameter int GHR_BITS = GHR_BITS_DEFAULT
);
  logic [31:0]         if_pc;
  logic                global_prediction;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                ex_valid;
  logic [31:0]         ex_pc;
  logic [GHR_BITS-1:0] ex_ghr;
  rv32i_control_word   idex_controlw;
  logic                br_en;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_ghr, idex_controlw, br_en,
    input  global_prediction, pred_ghr
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_ghr, idex_controlw, br_en,
    output global_prediction, pred_ghr
  );
endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state; purely combinational, shared by global and local predictors.
module sat_counter2
  import rv32i_types::*;
(
  input  bp_ctr_t state,
  input  logic    taken,
  output bp_ctr_t next_state
);

  always_comb begin
    next_state = state;
    case (state)
      CTR_SNT: next_state = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: next_state = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  next_state = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  next_state = taken ? CTR_ST  : CTR_WT;
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: zero-cycle lookup from if_pc, PHT/GHR trained on the edge after a resolved branch/jump.
// No backpressure; an update is taken every cycle it is presented and same-cycle lookups see the pre-update counter.
module gshare_predictor
  import rv32i_types::*;
#(
  parameter int GHR_BITS = GHR_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gshare_predictor_if.slave    bus
);

  localparam int PHT_DEPTH = 1 << GHR_BITS;

  logic [GHR_BITS-1:0] ghr;
  bp_ctr_t             pht [PHT_DEPTH];

  logic [GHR_BITS-1:0] lookup_idx;
  logic [GHR_BITS-1:0] upd_idx;
  bp_ctr_t             lookup_ctr;
  bp_ctr_t             upd_ctr;
  bp_ctr_t             upd_ctr_next;
  logic                upd_en;
  logic                taken;

  assign lookup_idx = bus.if_pc[GHR_BITS+1:2] ^ ghr;
  assign lookup_ctr = pht[lookup_idx];

  assign bus.global_prediction = lookup_ctr[1];
  assign bus.pred_ghr          = ghr;

  // Jumps always train taken regardless of the comparator result.
  assign taken   = (bus.idex_controlw.branch & bus.br_en) | bus.idex_controlw.jump;
  assign upd_en  = bus.ex_valid & (bus.idex_controlw.branch | bus.idex_controlw.jump);
  assign upd_idx = bus.ex_pc[GHR_BITS+1:2] ^ bus.ex_ghr;
  assign upd_ctr = pht[upd_idx];

  sat_counter2 u_ctr (
    .state      (upd_ctr),
    .taken      (taken),
    .next_state (upd_ctr_next)
  );

  // Flop array rather than RAM so every entry can reset and be read combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht[i] <= CTR_WNT;
      end
    end else if (upd_en) begin
      pht[upd_idx] <= upd_ctr_next;
      ghr          <= {ghr[GHR_BITS-2:0], taken};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.if_pc[31:GHR_BITS+2], bus.if_pc[1:0],
                         bus.ex_pc[31:GHR_BITS+2], bus.ex_pc[1:0],
                         bus.idex_controlw.opcode, bus.idex_controlw.funct3,
                         bus.idex_controlw.regwrite};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed test of the gshare predictor: reset, training, saturation, jumps, same-cycle lookup, async reset.
module tb_gshare_predictor;
  import rv32i_types::*;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  gshare_predictor_if #(.GHR_BITS(8)) bus ();

  gshare_predictor #(.GHR_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_ex();
    bus.ex_valid      = 1'b0;
    bus.ex_pc         = 32'h0;
    bus.ex_ghr        = 8'h00;
    bus.idex_controlw = '0;
    bus.br_en         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_ex();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic apply_update(input logic [31:0] pc, input logic [7:0] g,
                              input logic b, input logic j, input logic e, input logic v);
    @(negedge clk);
    bus.ex_pc                = pc;
    bus.ex_ghr               = g;
    bus.idex_controlw.branch = b;
    bus.idex_controlw.jump   = j;
    bus.br_en                = e;
    bus.ex_valid             = v;
    @(posedge clk);
    #1;
    clear_ex();
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_ex();
    bus.if_pc = 32'h60;
    #1;
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if (bus.global_prediction !== 1'b0) $display("FAIL reset_pred: actual=%b required=0", bus.global_prediction);
    else pass_cnt++;
    total_cnt++;
    if (bus.pred_ghr !== 8'h00) $display("FAIL reset_ghr: actual=%h required=00", bus.pred_ghr);
    else pass_cnt++;
    total_cnt++;
    if (dut.pht[8'h18] !== CTR_WNT) $display("FAIL reset_pht18: actual=%b required=01", dut.pht[8'h18]);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_taken_train();
    do_reset();
    apply_update(32'h60, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("train1_pht", {6'b0, dut.pht[8'h18]}, 8'h02);
    chk("train1_ghr", bus.pred_ghr, 8'h01);
    apply_update(32'h60, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("train2_pht", {6'b0, dut.pht[8'h18]}, 8'h03);
    chk("train2_ghr", bus.pred_ghr, 8'h03);
    bus.if_pc = 32'h6C;
    #1;
    chk("train_pred", {7'b0, bus.global_prediction}, 8'h01);
    chk("train_pred_ghr", bus.pred_ghr, 8'h03);
  endtask

  task automatic test_saturate_nt();
    logic [7:0] exp_ctr [4];
    exp_ctr = '{8'h00, 8'h00, 8'h00, 8'h00};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply_update(32'h60, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      chk($sformatf("nt%0d_pht", k), {6'b0, dut.pht[8'h18]}, exp_ctr[k]);
    end
    chk("nt_ghr", bus.pred_ghr, 8'h00);
    apply_update(32'h60, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("nt_then_t_pht", {6'b0, dut.pht[8'h18]}, 8'h01);
    chk("nt_then_t_ghr", bus.pred_ghr, 8'h01);
    bus.if_pc = 32'h64;
    #1;
    chk("nt_then_t_pred", {7'b0, bus.global_prediction}, 8'h00);
  endtask

  task automatic test_jump_and_hold();
    do_reset();
    apply_update(32'h40, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("jump_pht", {6'b0, dut.pht[8'h10]}, 8'h02);
    chk("jump_ghr", bus.pred_ghr, 8'h01);
    apply_update(32'h40, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("nonbr_pht", {6'b0, dut.pht[8'h10]}, 8'h02);
    chk("nonbr_ghr", bus.pred_ghr, 8'h01);
    apply_update(32'h40, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("novalid_pht", {6'b0, dut.pht[8'h10]}, 8'h02);
    chk("novalid_ghr", bus.pred_ghr, 8'h01);
    // Only ex_pc[9:2] may reach the index.
    apply_update(32'hFFFF_FC43, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("pcmask_pht", {6'b0, dut.pht[8'h10]}, 8'h03);
    chk("pcmask_ghr", bus.pred_ghr, 8'h03);
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.if_pc = 32'h60;
    @(negedge clk);
    bus.ex_pc                = 32'h60;
    bus.ex_ghr               = 8'h00;
    bus.idex_controlw.branch = 1'b1;
    bus.br_en                = 1'b1;
    bus.ex_valid             = 1'b1;
    #1;
    chk("same_cycle_pred", {7'b0, bus.global_prediction}, 8'h00);
    @(posedge clk);
    #1;
    clear_ex();
    bus.if_pc = 32'h64;
    #1;
    chk("next_cycle_pred", {7'b0, bus.global_prediction}, 8'h01);
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    apply_update(32'h60, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    apply_update(32'h60, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    bus.if_pc = 32'h6C;
    @(negedge clk);
    chk("pre_arst_pred", {7'b0, bus.global_prediction}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pred", {7'b0, bus.global_prediction}, 8'h00);
    chk("arst_ghr", bus.pred_ghr, 8'h00);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (dut.pht[i] !== CTR_WNT) bad++;
    chk("arst_all_wnt_bad", bad[7:0], 8'h00);
    // Update presented while reset is held must be discarded.
    bus.ex_pc                = 32'h60;
    bus.idex_controlw.branch = 1'b1;
    bus.br_en                = 1'b1;
    bus.ex_valid             = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_upd_pht", {6'b0, dut.pht[8'h18]}, 8'h01);
    chk("arst_upd_ghr", bus.pred_ghr, 8'h00);
    @(negedge clk);
    clear_ex();
    rst_n = 1'b1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_taken_train();
    test_saturate_nt();
    test_jump_and_hold();
    test_same_cycle();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
